// File: rtl/output_process_spi_pkg.sv
// Shared constants and FSM encoding for the outbound SPI word transmitter.
// OUTPUT_SPI_PARITY_EN adds one odd-parity period after bit0 of every word.
package output_process_spi_pkg;

   localparam int SPI_WORD_W      = 16;
   localparam int DEFAULT_CLK_DIV = 4;

`ifdef OUTPUT_SPI_PARITY_EN
   localparam int SPI_PARITY_BITS = 1;
`else
   localparam int SPI_PARITY_BITS = 0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      STROBE = 2'd2
   } spi_state_e;

endpackage

// File: rtl/output_process_spi_if.sv
// Writer-side and link-side signals of the SPI transmitter.
// The slave modport is the transmitter; the master modport is the writer/remote end.
interface output_process_spi_if #(parameter int DEPTH = 256);
   import output_process_spi_pkg::*;

   localparam int USED_W = $clog2(DEPTH) + 1;

   logic                  WR_REQ;
   logic [SPI_WORD_W-1:0] WR_DATA;
   logic                  WR_FULL;
   logic [USED_W-1:0]     USED;
   logic                  TX_CLK;
   logic                  TX_DATA;
   logic                  TX_LOAD;
   logic                  TX_STOP;
   logic                  BUSY;
   logic                  MSG_DONE;
   logic [15:0]           WORDS_SENT;

   modport master (
      output WR_REQ, WR_DATA, TX_STOP,
      input  WR_FULL, USED, TX_CLK, TX_DATA, TX_LOAD, BUSY, MSG_DONE, WORDS_SENT
   );

   modport slave (
      input  WR_REQ, WR_DATA, TX_STOP,
      output WR_FULL, USED, TX_CLK, TX_DATA, TX_LOAD, BUSY, MSG_DONE, WORDS_SENT
   );

endinterface

// File: rtl/output_process_spi_serializer.sv
// Shift register, half-period divider and bit counter for one SPI word plus strobe period.
// Builds with an extra odd-parity bit when OUTPUT_SPI_PARITY_EN is defined.
module output_process_spi_serializer
   import output_process_spi_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV,
   parameter int WORD_W  = SPI_WORD_W
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [WORD_W-1:0] word,
   output logic              bits_done,
   output logic              done,
   output logic              TX_CLK,
   output logic              TX_DATA,
   output logic              TX_LOAD
);

   localparam int NB = WORD_W + SPI_PARITY_BITS;
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(NB + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);

   logic [NB-1:0] payload, sreg_q;
   logic [DW-1:0] div_q;
   logic [BW-1:0] bit_q;
   logic          active_q, strobe_q, clk_q, data_q, load_q;
   logic          half_end, bit_end;

`ifdef OUTPUT_SPI_PARITY_EN
   assign payload = {word, ~^word};
`else
   assign payload = word;
`endif

   assign half_end  = active_q && (div_q == DIV_LAST);
   assign bit_end   = half_end && clk_q;
   assign bits_done = bit_end && !strobe_q && (bit_q == BIT_LAST);
   assign done      = bit_end && strobe_q;

   // Data and load only move on the edge that drops TX_CLK, so both are stable across the rise.
   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         active_q <= 1'b0;
         strobe_q <= 1'b0;
         clk_q    <= 1'b0;
         data_q   <= 1'b0;
         load_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sreg_q   <= '0;
      end else if (start) begin
         active_q <= 1'b1;
         strobe_q <= 1'b0;
         clk_q    <= 1'b0;
         data_q   <= payload[NB-1];
         load_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sreg_q   <= {payload[NB-2:0], 1'b0};
      end else if (active_q) begin
         div_q <= half_end ? '0 : div_q + 1'b1;
         if (half_end) begin
            clk_q <= ~clk_q;
            if (clk_q) begin
               if (strobe_q) begin
                  active_q <= 1'b0;
                  strobe_q <= 1'b0;
                  load_q   <= 1'b0;
               end else if (bit_q == BIT_LAST) begin
                  strobe_q <= 1'b1;
                  load_q   <= 1'b1;
                  data_q   <= 1'b0;
               end else begin
                  bit_q  <= bit_q + 1'b1;
                  data_q <= sreg_q[NB-1];
                  sreg_q <= {sreg_q[NB-2:0], 1'b0};
               end
            end
         end
      end
   end

   assign TX_CLK  = clk_q;
   assign TX_DATA = data_q;
   assign TX_LOAD = load_q;

endmodule

// File: rtl/output_process_spi.sv
// SPI word transmitter: show-ahead FIFO, TX_STOP synchroniser, word FSM and counters.
// Define OUTPUT_SPI_PARITY_EN to append an odd-parity period to every word.
module output_process_spi
   import output_process_spi_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int CLK_DIV = DEFAULT_CLK_DIV,
   parameter int WORD_W  = SPI_WORD_W
) (
   input logic                  SYS_CLK,
   input logic                  RST,
   output_process_spi_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       used_q;
   logic              full, wr_en, pop;
   logic [1:0]        stop_pipe;
   spi_state_e        state_q, state_d;
   logic              bits_done, done, msg_done_q;
   logic [15:0]       words_sent_q;
   logic              tx_clk, tx_data, tx_load;

   assign full  = (used_q == (AW+1)'(DEPTH));
   assign wr_en = bus.WR_REQ && !full;

   always_ff @(posedge SYS_CLK) begin
      if (wr_en) mem[wr_ptr] <= bus.WR_DATA;
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used_q <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         used_q <= used_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
   end

   // TX_STOP comes from the remote clock domain.
   always_ff @(posedge SYS_CLK) begin
      if (RST) stop_pipe <= 2'b00;
      else     stop_pipe <= {stop_pipe[0], bus.TX_STOP};
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Back-pressure is only honoured between words; a word in flight always completes.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (used_q != '0 && !stop_pipe[1]) begin
            pop     = 1'b1;
            state_d = SHIFT;
         end
         SHIFT:   if (bits_done) state_d = STROBE;
         STROBE:  if (done)      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         words_sent_q <= '0;
         msg_done_q   <= 1'b0;
      end else begin
         msg_done_q <= done && (used_q == '0);
         if (done) words_sent_q <= words_sent_q + 1'b1;
      end
   end

   output_process_spi_serializer #(
      .CLK_DIV (CLK_DIV),
      .WORD_W  (WORD_W)
   ) u_ser (
      .SYS_CLK   (SYS_CLK),
      .RST       (RST),
      .start     (pop),
      .word      (mem[rd_ptr]),
      .bits_done (bits_done),
      .done      (done),
      .TX_CLK    (tx_clk),
      .TX_DATA   (tx_data),
      .TX_LOAD   (tx_load)
   );

   assign bus.WR_FULL    = full;
   assign bus.USED       = used_q;
   assign bus.TX_CLK     = tx_clk;
   assign bus.TX_DATA    = tx_data;
   assign bus.TX_LOAD    = tx_load;
   assign bus.BUSY       = (state_q != IDLE);
   assign bus.MSG_DONE   = msg_done_q;
   assign bus.WORDS_SENT = words_sent_q;

endmodule

// File: tb/tb_output_process_spi.sv
// Directed + random bench: a link-level receiver model rebuilds frames from TX_CLK/TX_LOAD.
module tb_output_process_spi;
   import output_process_spi_pkg::*;

   localparam int CD    = 4;
   localparam int DEPTH = 256;
   localparam int NB    = SPI_WORD_W + SPI_PARITY_BITS;
   localparam int FT    = (2*NB + 2)*CD + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   output_process_spi_if #(.DEPTH(DEPTH)) bus();

   output_process_spi #(.DEPTH(DEPTH), .CLK_DIV(CD), .WORD_W(SPI_WORD_W)) dut (
      .SYS_CLK (clk),
      .RST     (rst),
      .bus     (bus)
   );

   int checks = 0, errors = 0;
   int cyc = 0, nb = 0, loads = 0, msgs = 0, msg_last = 0, viol = 0, sent = 0;
   logic [31:0] acc = '0;
   logic p_clk = 1'b0, p_data = 1'b0, p_load = 1'b0, p_busy = 1'b0;
   logic [31:0] rx_q[$];
   int          rx_n[$];
   int          starts[$];
   logic [31:0] exp_q[$];

   // Receiver: shift in TX_DATA on each TX_CLK rise, latch the word on the rise with TX_LOAD.
   always begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         acc = '0;
         nb  = 0;
      end else if (bus.TX_CLK && !p_clk) begin
         if (bus.TX_LOAD) begin
            rx_q.push_back(acc);
            rx_n.push_back(nb);
            acc = '0;
            nb  = 0;
         end else begin
            acc = {acc[30:0], bus.TX_DATA};
            nb++;
         end
      end
      if (bus.TX_LOAD && !p_load) loads++;
      if (bus.BUSY && !p_busy) starts.push_back(cyc);
      if (bus.MSG_DONE) begin
         msgs++;
         msg_last = cyc;
      end
      if (bus.TX_CLK && (bus.TX_DATA !== p_data || bus.TX_LOAD !== p_load)) viol++;
      p_clk  = bus.TX_CLK;
      p_data = bus.TX_DATA;
      p_load = bus.TX_LOAD;
      p_busy = bus.BUSY;
   end

   function automatic logic [31:0] frame_of(logic [15:0] w);
      logic [31:0] f;
      f = 32'(w);
      if (NB > SPI_WORD_W) f = {f[30:0], ($countones(w) % 2 == 0)};
      return f;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(logic [15:0] w);
      bus.WR_REQ  = 1'b1;
      bus.WR_DATA = w;
      tick(1);
      bus.WR_REQ  = 1'b0;
      exp_q.push_back(frame_of(w));
      sent++;
   endtask

   task automatic wait_frames(string tag, int n, int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk({tag, "_timeout"}, 32'(rx_q.size() >= n), 32'd1);
      k = 0;
      while (bus.BUSY && k < 50) begin
         tick(1);
         k++;
      end
      tick(2);
   endtask

   task automatic wait_bits(string tag, int n);
      int k;
      k = 0;
      while (nb < n && k < FT) begin
         tick(1);
         k++;
      end
      chk({tag, "_bits_timeout"}, 32'(nb >= n), 32'd1);
   endtask

   task automatic cmp_frames(string tag);
      logic [31:0] e, r;
      int          n;
      chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
         n = (rx_n.size() > 0) ? rx_n.pop_front() : -1;
         chk({tag, "_word"}, r, e);
         chk({tag, "_nbits"}, 32'(n), 32'(NB));
      end
   endtask

   initial begin
      logic [15:0] b2b [3];
      int m0, s0, l0, occ, gap;
      logic [15:0] w;

      bus.WR_REQ  = 1'b0;
      bus.WR_DATA = '0;
      bus.TX_STOP = 1'b0;
      tick(3);
      chk("rst_used",    32'(bus.USED), 32'd0);
      chk("rst_full",    32'(bus.WR_FULL), 32'd0);
      chk("rst_txclk",   32'(bus.TX_CLK), 32'd0);
      chk("rst_txdata",  32'(bus.TX_DATA), 32'd0);
      chk("rst_txload",  32'(bus.TX_LOAD), 32'd0);
      chk("rst_busy",    32'(bus.BUSY), 32'd0);
      chk("rst_msgdone", 32'(bus.MSG_DONE), 32'd0);
      chk("rst_sent",    32'(bus.WORDS_SENT), 32'd0);
      rst = 1'b0;
      tick(2);

      // single word
      m0 = msgs;
      wr(16'hA5C3);
      wait_frames("single", 1, FT + 50);
      cmp_frames("single");
      chk("single_msg",  32'(msgs - m0), 32'd1);
      chk("single_sent", 32'(bus.WORDS_SENT), 32'(sent));
      chk("single_busy", 32'(bus.BUSY), 32'd0);

      // three consecutive writes
      b2b = '{16'h0001, 16'hFFFF, 16'h8000};
      m0 = msgs;
      s0 = starts.size();
      for (int i = 0; i < 3; i++) begin
         bus.WR_REQ  = 1'b1;
         bus.WR_DATA = b2b[i];
         tick(1);
         exp_q.push_back(frame_of(b2b[i]));
         sent++;
      end
      bus.WR_REQ = 1'b0;
      wait_frames("b2b", 3, 3*FT + 50);
      chk("b2b_gap1", 32'(starts[s0+1] - starts[s0]), 32'(FT));
      chk("b2b_gap2", 32'(starts[s0+2] - starts[s0+1]), 32'(FT));
      chk("b2b_msg",  32'(msgs - m0), 32'd1);
      chk("b2b_msg_after_third", 32'(msg_last > starts[s0+2]), 32'd1);
      cmp_frames("b2b");
      chk("b2b_sent", 32'(bus.WORDS_SENT), 32'(sent));

      // random words with random gaps, some landing mid-frame
      for (int i = 0; i < 6; i++) begin
         w = (i == 0) ? 16'h0003 : 16'($urandom);
         wr(w);
         gap = $urandom_range(0, 3);
         if (gap > 0) tick(gap);
      end
      wait_frames("rand", 6, 6*FT + 100);
      cmp_frames("rand");
      chk("rand_sent", 32'(bus.WORDS_SENT), 32'(sent));

      // fill while the remote end is stalled
      bus.TX_STOP = 1'b1;
      tick(3);
      occ = 0;
      for (int i = 0; i <= DEPTH; i++) begin
         w = 16'($urandom);
         bus.WR_REQ  = 1'b1;
         bus.WR_DATA = w;
         if (occ < DEPTH) begin
            exp_q.push_back(frame_of(w));
            occ++;
            sent++;
         end
         tick(1);
         if (i == DEPTH - 1) begin
            chk("full_flag", 32'(bus.WR_FULL), 32'd1);
            chk("full_used", 32'(bus.USED), 32'(DEPTH));
         end
      end
      bus.WR_REQ = 1'b0;
      chk("full_drop_used", 32'(bus.USED), 32'(DEPTH));
      chk("full_stalled",   32'(bus.BUSY), 32'd0);
      bus.TX_STOP = 1'b0;
      wait_frames("full", DEPTH, DEPTH*FT + 200);
      cmp_frames("full");
      chk("full_sent",  32'(bus.WORDS_SENT), 32'(sent));
      chk("full_empty", 32'(bus.USED), 32'd0);

      // back-pressure raised mid-word
      m0 = msgs;
      wr(16'($urandom));
      wr(16'($urandom));
      wait_bits("bp", 5);
      bus.TX_STOP = 1'b1;
      wait_frames("bp1", 1, FT);
      tick(20);
      chk("bp_hold_busy", 32'(bus.BUSY), 32'd0);
      chk("bp_hold_used", 32'(bus.USED), 32'd1);
      chk("bp_hold_rx",   32'(rx_q.size()), 32'd1);
      bus.TX_STOP = 1'b0;
      tick(2);
      chk("bp_resume_early", 32'(bus.BUSY), 32'd0);
      tick(1);
      chk("bp_resume", 32'(bus.BUSY), 32'd1);
      wait_frames("bp2", 2, FT + 50);
      cmp_frames("bp");
      chk("bp_msg", 32'(msgs - m0), 32'd1);

      // reset in the middle of a word: nothing may be latched
      l0 = loads;
      bus.WR_REQ  = 1'b1;
      bus.WR_DATA = 16'($urandom);
      tick(1);
      bus.WR_DATA = 16'($urandom);
      tick(1);
      bus.WR_REQ = 1'b0;
      wait_bits("rst", 8);
      rst = 1'b1;
      tick(1);
      chk("midrst_used",   32'(bus.USED), 32'd0);
      chk("midrst_txclk",  32'(bus.TX_CLK), 32'd0);
      chk("midrst_txdata", 32'(bus.TX_DATA), 32'd0);
      chk("midrst_txload", 32'(bus.TX_LOAD), 32'd0);
      chk("midrst_busy",   32'(bus.BUSY), 32'd0);
      chk("midrst_sent",   32'(bus.WORDS_SENT), 32'd0);
      rst = 1'b0;
      sent = 0;
      tick(3*FT);
      chk("midrst_no_load", 32'(loads - l0), 32'd0);
      chk("midrst_no_rx",   32'(rx_q.size()), 32'd0);
      chk("midrst_idle",    32'(bus.BUSY), 32'd0);
      chk("midrst_sent2",   32'(bus.WORDS_SENT), 32'(sent));

      chk("data_stable_high_clk", 32'(viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
